paddle_ctrl: RTL and testbench
==============================

Name: paddle_ctrl

Overview:
- Converts the keyboard byte stream into the vertical positions of the two pong paddles.
- Sits between the PS/2 receiver (byte + strobe) and the pong top. Its outputs feed VGAController (drawing) and the ball logic (collision).
- Decodes PS/2 set-2 make/break sequences into four key-held flags, then moves each paddle by a fixed step on every game-tick pulse, clamped to the screen.

Parameters:
- SCREEN_H, 480, visible lines.
- PADDLE_H, 64, paddle height in lines.
- STEP, 4, lines moved per tick while a key is held (1..PADDLE_H).
- Y_W, 9, width of the paddle y outputs (top edge, same width as ball_y).

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-low reset.
- tick  in  1  single-cycle game-update enable (e.g. rising edge of the divided 50 Hz strobe).
- ps2_byte  in  8  received scan-code byte.
- ps2_valid  in  1  single-cycle strobe; ps2_byte is valid this cycle.
- left_y  out  Y_W  left paddle top-edge y.
- right_y  out  Y_W  right paddle top-edge y.
- keys_held  out  4  {dn_R, up_R, dn_L, up_L} held flags, for debug/LEDs.

Behaviour:
- Single clock domain. reset==0 at a clk edge forces:
  - left_y = right_y = (SCREEN_H-PADDLE_H)/2, which is 208 by default.
  - keys_held = 0.
  - decoder FSM = IDLE.
- Key map (set 2):
  - up_L = 0x1D (W), dn_L = 0x1B (S).
  - up_R = E0 75 (Up arrow), dn_R = E0 72 (Down arrow).
- Decoder FSM advances only on cycles with ps2_valid=1. States IDLE, EXT, BRK, EXT_BRK:
  - IDLE: E0 -> EXT; F0 -> BRK; 1D/1B -> set up_L/dn_L, stay IDLE; any other byte ignored, stay IDLE.
  - EXT: F0 -> EXT_BRK; 75/72 -> set up_R/dn_R, then IDLE; any other byte -> IDLE, no flag change.
  - BRK: 1D/1B -> clear up_L/dn_L; any byte -> IDLE.
  - EXT_BRK: 75/72 -> clear up_R/dn_R; any byte -> IDLE.
  - Non-extended 75/72 (keypad 8/2) never affect the R flags. Extended 1D/1B never affect the L flags.
  - Typematic repeat (repeated make codes) re-sets an already-set flag: no effect.
- Flag latency: a flag changes on the clk edge that samples the final byte of its sequence and is visible the next cycle.
- Paddle update on a cycle with tick=1, each paddle independently, using the flags registered before this edge:
  - up only: y <= (y < STEP) ? 0 : y-STEP.
  - down only: y <= (y+STEP > SCREEN_H-PADDLE_H) ? SCREEN_H-PADDLE_H : y+STEP.
  - both or neither held: y unchanged.
  - Compare/add at Y_W+1 bits; no wrap-around is permitted.
- Position latency: y changes on the tick edge and is visible the following cycle. With no tick, y never changes.
- Range invariant: 0 <= y <= SCREEN_H-PADDLE_H (416) at all times.
- Simultaneous tick and ps2_valid: the tick uses the old flags, the byte updates the flags. The new flag takes effect at the next tick.
- Reset mid-sequence (e.g. after E0 F0) returns the FSM to IDLE. The next byte is decoded from IDLE.
- Outputs are registered; there are no combinational paths from the inputs.

Test Plan:
- Reset then release: left_y=right_y=208, keys_held=0000.
- Send 1D; pulse tick 3 times -> left_y=196, right_y=208. Then send F0 1D; pulse tick -> left_y stays 196, keys_held=0000.
- Send E0 72; pulse tick 60 times -> right_y clamps at 416 and never exceeds it. Then send E0 F0 72 -> keys_held[3]=0.
- Send 1D and 1B (both held); pulse tick 5 times -> left_y=208. Release only 1B (F0 1B); pulse tick -> left_y=204.
- Send plain 72 (no E0) -> keys_held unchanged. Send E0 1D -> up_L unchanged. Send E0 F0, assert reset, then send 1D -> up_L set (FSM was reset to IDLE).
- Hold up_L; pulse tick 60 times -> left_y=0 with no underflow. On a cycle where tick and the final byte of F0 1D coincide, left_y still decrements once (old flags used).

Source files
------------

// File: rtl/paddle_if.sv
// Keyboard/tick inputs and paddle position outputs between the pong top and paddle_ctrl.
interface paddle_if #(
  parameter int unsigned Y_W = 9
);
  logic           tick;
  logic [7:0]     ps2_byte;
  logic           ps2_valid;
  logic [Y_W-1:0] left_y;
  logic [Y_W-1:0] right_y;
  logic [3:0]     keys_held;

  modport master (
    output tick, ps2_byte, ps2_valid,
    input  left_y, right_y, keys_held
  );

  modport slave (
    input  tick, ps2_byte, ps2_valid,
    output left_y, right_y, keys_held
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Decodes PS/2 set-2 make/break codes into four held-key flags and steps both
// paddles on each game tick, clamped to the visible area.
module paddle_ctrl #(
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned PADDLE_H = 64,
  parameter int unsigned STEP     = 4,
  parameter int unsigned Y_W      = 9
) (
  input logic     clk,
  input logic     reset,
  paddle_if.slave bus
);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_UPL = 8'h1D;
  localparam logic [7:0] CODE_DNL = 8'h1B;
  localparam logic [7:0] CODE_UPR = 8'h75;
  localparam logic [7:0] CODE_DNR = 8'h72;

  localparam logic [Y_W:0]   Y_MAX   = (Y_W+1)'(SCREEN_H - PADDLE_H);
  localparam logic [Y_W:0]   Y_STEP  = (Y_W+1)'(STEP);
  localparam logic [Y_W-1:0] Y_RESET = Y_W'((SCREEN_H - PADDLE_H) / 2);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t         state, state_nxt;
  logic [3:0]     keys_q, keys_nxt;
  logic [Y_W-1:0] left_q, left_nxt;
  logic [Y_W-1:0] right_q, right_nxt;

  // One tick of motion; arithmetic is one bit wider so neither end can wrap.
  function automatic logic [Y_W-1:0] move(input logic [Y_W-1:0] y,
                                          input logic up, input logic dn);
    logic [Y_W:0] ext;
    logic [Y_W:0] res;
    ext = {1'b0, y};
    res = ext;
    if (up && !dn) begin
      res = (ext < Y_STEP) ? '0 : ext - Y_STEP;
    end else if (dn && !up) begin
      res = (ext + Y_STEP > Y_MAX) ? Y_MAX : ext + Y_STEP;
    end
    return Y_W'(res);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      keys_q  <= '0;
      left_q  <= Y_RESET;
      right_q <= Y_RESET;
    end else begin
      state   <= state_nxt;
      keys_q  <= keys_nxt;
      left_q  <= left_nxt;
      right_q <= right_nxt;
    end
  end

  // Scan-code decoder: the state only records which prefixes have been seen.
  always_comb begin
    state_nxt = state;
    keys_nxt  = keys_q;
    if (bus.ps2_valid) begin
      case (state)
        IDLE: begin
          if (bus.ps2_byte == CODE_EXT)      state_nxt   = EXT;
          else if (bus.ps2_byte == CODE_BRK) state_nxt   = BRK;
          else if (bus.ps2_byte == CODE_UPL) keys_nxt[0] = 1'b1;
          else if (bus.ps2_byte == CODE_DNL) keys_nxt[1] = 1'b1;
        end
        EXT: begin
          state_nxt = IDLE;
          if (bus.ps2_byte == CODE_BRK)      state_nxt   = EXT_BRK;
          else if (bus.ps2_byte == CODE_UPR) keys_nxt[2] = 1'b1;
          else if (bus.ps2_byte == CODE_DNR) keys_nxt[3] = 1'b1;
        end
        BRK: begin
          state_nxt = IDLE;
          if (bus.ps2_byte == CODE_UPL)      keys_nxt[0] = 1'b0;
          else if (bus.ps2_byte == CODE_DNL) keys_nxt[1] = 1'b0;
        end
        EXT_BRK: begin
          state_nxt = IDLE;
          if (bus.ps2_byte == CODE_UPR)      keys_nxt[2] = 1'b0;
          else if (bus.ps2_byte == CODE_DNR) keys_nxt[3] = 1'b0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Motion uses the flags registered before this edge.
  always_comb begin
    left_nxt  = left_q;
    right_nxt = right_q;
    if (bus.tick) begin
      left_nxt  = move(left_q,  keys_q[0], keys_q[1]);
      right_nxt = move(right_q, keys_q[2], keys_q[3]);
    end
  end

  assign bus.left_y    = left_q;
  assign bus.right_y   = right_q;
  assign bus.keys_held = keys_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed and randomized bench for paddle_ctrl against a sequence-level keyboard
// model and plain clamped arithmetic for the paddle positions.
module tb_paddle_ctrl;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  paddle_if #(.Y_W(9)) bus ();

  paddle_ctrl #(.SCREEN_H(480), .PADDLE_H(64), .STEP(4), .Y_W(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bytes are gathered until a complete make/break sequence
  // is seen, then the sequence as a whole is interpreted.
  int         ml, mr;
  bit [3:0]   mk;
  logic [7:0] seq[$];
  bit         model_ok = 0;

  function automatic int model_move(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
    if (dn && !up) return (y + 4 > 416) ? 416 : y + 4;
    return y;
  endfunction

  function automatic bit is_prefix();
    if (seq.size() == 1 && (seq[0] == 8'hE0 || seq[0] == 8'hF0)) return 1;
    if (seq.size() == 2 && seq[0] == 8'hE0 && seq[1] == 8'hF0) return 1;
    return 0;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    bit ext, brk;
    int idx;
    seq.push_back(b);
    if (is_prefix()) return;
    ext = (seq[0] == 8'hE0);
    brk = (seq[0] == 8'hF0) || (ext && seq.size() > 1 && seq[1] == 8'hF0);
    idx = -1;
    if (ext) begin
      if (b == 8'h75) idx = 2;
      if (b == 8'h72) idx = 3;
    end else begin
      if (b == 8'h1D) idx = 0;
      if (b == 8'h1B) idx = 1;
    end
    if (idx >= 0) mk[idx] = !brk;
    seq.delete();
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      ml = 208; mr = 208; mk = '0; seq.delete(); model_ok = 1;
    end else begin
      if (bus.tick) begin
        ml = model_move(ml, mk[0], mk[1]);
        mr = model_move(mr, mk[2], mk[3]);
      end
      if (bus.ps2_valid) model_byte(bus.ps2_byte);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      checks += 3;
      if (int'(bus.left_y) != ml) begin
        errors++;
        $display("FAIL cyc_left_y t=%0t got=%0d exp=%0d", $time, bus.left_y, ml);
      end
      if (int'(bus.right_y) != mr) begin
        errors++;
        $display("FAIL cyc_right_y t=%0t got=%0d exp=%0d", $time, bus.right_y, mr);
      end
      if (bus.keys_held !== mk) begin
        errors++;
        $display("FAIL cyc_keys t=%0t got=%b exp=%b", $time, bus.keys_held, mk);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step(input logic t, input logic v, input logic [7:0] b);
    @(negedge clk);
    bus.tick = t; bus.ps2_valid = v; bus.ps2_byte = b;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, b);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic settle();
    step(1'b0, 1'b0, 8'h00);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; bus.tick = 1'b0; bus.ps2_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [7:0] codes [7] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h75, 8'h72, 8'h00};

  initial begin
    reset = 1'b0;
    bus.tick = 1'b0; bus.ps2_valid = 1'b0; bus.ps2_byte = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    settle();
    chk("rst_left", int'(bus.left_y), 208);
    chk("rst_right", int'(bus.right_y), 208);
    chk("rst_keys", int'(bus.keys_held), 0);

    send(8'h1D); ticks(3); settle();
    chk("upl_3tick_left", int'(bus.left_y), 196);
    chk("upl_3tick_right", int'(bus.right_y), 208);
    send(8'hF0); send(8'h1D); ticks(1); settle();
    chk("upl_rel_left", int'(bus.left_y), 196);
    chk("upl_rel_keys", int'(bus.keys_held), 0);

    send(8'hE0); send(8'h72); settle();
    chk("dnr_keys", int'(bus.keys_held), 8);
    ticks(60); settle();
    chk("dnr_clamp", int'(bus.right_y), 416);
    send(8'hE0); send(8'hF0); send(8'h72); settle();
    chk("dnr_rel_keys", int'(bus.keys_held), 0);

    do_reset();
    send(8'h1D); send(8'h1B); ticks(5); settle();
    chk("both_held_left", int'(bus.left_y), 208);
    send(8'hF0); send(8'h1B); ticks(1); settle();
    chk("rel_dnl_left", int'(bus.left_y), 204);
    send(8'hF0); send(8'h1D); settle();
    chk("all_rel_keys", int'(bus.keys_held), 0);

    send(8'h72); settle();
    chk("keypad2_keys", int'(bus.keys_held), 0);
    send(8'hE0); send(8'h1D); settle();
    chk("ext_1d_keys", int'(bus.keys_held), 0);
    send(8'hE0); send(8'hF0); do_reset(); send(8'h1D); settle();
    chk("rst_mid_seq_keys", int'(bus.keys_held), 1);

    ticks(60); settle();
    chk("upl_floor", int'(bus.left_y), 0);

    do_reset();
    send(8'h1D); ticks(2);
    send(8'hF0); step(1'b1, 1'b1, 8'h1D); settle();
    chk("coincide_left", int'(bus.left_y), 196);
    chk("coincide_keys", int'(bus.keys_held), 0);
    ticks(1); settle();
    chk("after_coincide_left", int'(bus.left_y), 196);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] b;
      int k;
      k = $urandom_range(0, 6);
      b = (k == 6) ? 8'($urandom_range(0, 255)) : codes[k];
      @(negedge clk);
      reset         = ($urandom_range(0, 299) != 0);
      bus.tick      = ($urandom_range(0, 3) == 0);
      bus.ps2_valid = ($urandom_range(0, 1) == 0);
      bus.ps2_byte  = b;
    end
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
